// File: rtl/regfile_wb.sv
// Register file fed by the write-back stage. Destination addresses are carried in a
// 2-deep delay line so they line up with wr_en_RF / Data_In_RF.
module regfile_wb #(
   parameter int unsigned DEPTH = 32,
   parameter int unsigned XLEN  = 32,
   parameter int unsigned AW    = 5
) (
   input  logic            clk,
   input  logic            rst,
   input  logic [AW-1:0]   rd_addr,
   input  logic            rd_issue,
   input  logic [AW-1:0]   rs1_addr,
   input  logic [AW-1:0]   rs2_addr,
   input  logic            wr_en_RF,
   input  logic [XLEN-1:0] Data_In_RF,
   output logic [XLEN-1:0] rs1_data,
   output logic [XLEN-1:0] rs2_data,
   output logic            hazard,
   output logic            wb_err
);

   logic [XLEN-1:0] regs_q [DEPTH];
   logic            s1_valid_q, s2_valid_q;
   logic [AW-1:0]   s1_addr_q, s2_addr_q;
   logic            wb_err_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int unsigned i = 0; i < DEPTH; i++) begin
            regs_q[i] <= '0;
         end
         s1_valid_q <= 1'b0;
         s1_addr_q  <= '0;
         s2_valid_q <= 1'b0;
         s2_addr_q  <= '0;
         wb_err_q   <= 1'b0;
      end else begin
         // Address follows rd_addr every cycle; only the valid bit marks a real write.
         s1_valid_q <= rd_issue;
         s1_addr_q  <= rd_addr;
         s2_valid_q <= s1_valid_q;
         s2_addr_q  <= s1_addr_q;
         if (wr_en_RF && (s2_addr_q != '0)) begin
            regs_q[s2_addr_q] <= Data_In_RF;
         end
         if (wr_en_RF != s2_valid_q) begin
            wb_err_q <= 1'b1;
         end
      end
   end

   // Write-through: data being written this cycle is visible to decode immediately.
   always_comb begin
      rs1_data = '0;
      if (rs1_addr != '0) begin
         rs1_data = (wr_en_RF && (s2_addr_q == rs1_addr)) ? Data_In_RF : regs_q[rs1_addr];
      end
   end

   always_comb begin
      rs2_data = '0;
      if (rs2_addr != '0) begin
         rs2_data = (wr_en_RF && (s2_addr_q == rs2_addr)) ? Data_In_RF : regs_q[rs2_addr];
      end
   end

   logic hz1, hz2;

   // An s2 match with wr_en_RF high is served by the bypass, so it is not a hazard.
   always_comb begin
      hz1 = (rs1_addr != '0) &&
            ((s1_valid_q && (s1_addr_q == rs1_addr)) ||
             (s2_valid_q && (s2_addr_q == rs1_addr) && !wr_en_RF));
      hz2 = (rs2_addr != '0) &&
            ((s1_valid_q && (s1_addr_q == rs2_addr)) ||
             (s2_valid_q && (s2_addr_q == rs2_addr) && !wr_en_RF));
      hazard = hz1 || hz2;
   end

   assign wb_err = wb_err_q;

endmodule

// File: tb/tb_regfile_wb.sv
// Scoreboard bench for regfile_wb: stimulus queues expected outputs per cycle,
// a negedge monitor pops and compares them.
module tb_regfile_wb;

   logic        clk = 1'b0;
   logic        rst;
   logic [4:0]  rd_addr, rs1_addr, rs2_addr;
   logic        rd_issue, wr_en_RF;
   logic [31:0] Data_In_RF, rs1_data, rs2_data;
   logic        hazard, wb_err;

   int checks   = 0;
   int failures = 0;

   typedef struct {
      string       nm;
      logic [31:0] r1;
      logic [31:0] r2;
      logic        hz;
      logic        er;
   } exp_t;

   exp_t exp_q[$];

   regfile_wb #(.DEPTH(32), .XLEN(32), .AW(5)) dut (
      .clk        (clk),
      .rst        (rst),
      .rd_addr    (rd_addr),
      .rd_issue   (rd_issue),
      .rs1_addr   (rs1_addr),
      .rs2_addr   (rs2_addr),
      .wr_en_RF   (wr_en_RF),
      .Data_In_RF (Data_In_RF),
      .rs1_data   (rs1_data),
      .rs2_data   (rs2_data),
      .hazard     (hazard),
      .wb_err     (wb_err)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not complete");
      $fatal(1, "timeout");
   end

   task automatic chk(input string nm, input string fld, input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s.%s: got %h expected %h", nm, fld, act, exp);
      end
   endtask

   // Monitor: outputs are stable mid-cycle, compare against the queued entry.
   always @(negedge clk) begin
      if (exp_q.size() > 0) begin
         exp_t e;
         e = exp_q.pop_front();
         chk(e.nm, "rs1_data", rs1_data, e.r1);
         chk(e.nm, "rs2_data", rs2_data, e.r2);
         chk(e.nm, "hazard", {31'd0, hazard}, {31'd0, e.hz});
         chk(e.nm, "wb_err", {31'd0, wb_err}, {31'd0, e.er});
      end
   end

   // Drive one cycle of inputs, queue expected outputs, advance past the edge.
   task automatic cyc(input string nm, input logic r, input logic iss, input logic [4:0] rd,
                      input logic [4:0] a1, input logic [4:0] a2, input logic wen,
                      input logic [31:0] din, input logic [31:0] e1, input logic [31:0] e2,
                      input logic ehz, input logic eer);
      exp_t e;
      rst        = r;
      rd_issue   = iss;
      rd_addr    = rd;
      rs1_addr   = a1;
      rs2_addr   = a2;
      wr_en_RF   = wen;
      Data_In_RF = din;
      e.nm = nm; e.r1 = e1; e.r2 = e2; e.hz = ehz; e.er = eer;
      exp_q.push_back(e);
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst = 1'b1; rd_issue = 1'b0; rd_addr = '0; rs1_addr = '0; rs2_addr = '0;
      wr_en_RF = 1'b0; Data_In_RF = '0;
      repeat (2) @(posedge clk);
      #1;

      for (int i = 0; i < 32; i++) begin
         cyc("reset_read", 0, 0, 0, 5'(i), 5'(31 - i), 0, 0, 0, 0, 0, 0);
      end

      // x5 single write
      cyc("x5_T",   0, 1, 5, 5, 0, 0, 0,            0,            0, 0, 0);
      cyc("x5_T1",  0, 0, 0, 5, 0, 0, 0,            0,            0, 1, 0);
      cyc("x5_T2",  0, 0, 0, 5, 0, 1, 32'h000ABCDE, 32'h000ABCDE, 0, 0, 0);
      cyc("x5_T3",  0, 0, 0, 5, 0, 0, 0,            32'h000ABCDE, 0, 0, 0);

      // x0 write discarded
      cyc("x0_T",   0, 1, 0, 0, 5, 0, 0,            0, 32'h000ABCDE, 0, 0);
      cyc("x0_T1",  0, 0, 0, 0, 5, 0, 0,            0, 32'h000ABCDE, 0, 0);
      cyc("x0_T2",  0, 0, 0, 0, 5, 1, 32'hFFFFFFFF, 0, 32'h000ABCDE, 0, 0);
      cyc("x0_T3",  0, 0, 0, 0, 5, 0, 0,            0, 32'h000ABCDE, 0, 0);

      // x7 then x8 back to back
      cyc("x78_T",  0, 1, 7, 0, 0, 0, 0,     0,     0,     0, 0);
      cyc("x78_T1", 0, 1, 8, 7, 0, 0, 0,     0,     0,     1, 0);
      cyc("x78_T2", 0, 0, 0, 7, 8, 1, 32'h11, 32'h11, 0,     1, 0);
      cyc("x78_T3", 0, 0, 0, 7, 8, 1, 32'h22, 32'h11, 32'h22, 0, 0);
      cyc("x78_T4", 0, 0, 0, 7, 8, 0, 0,     32'h11, 32'h22, 0, 0);

      // Two in-flight writes to x9: later wins, hazard until s1 clears
      cyc("x99_T",  0, 1, 9, 0, 0, 0, 0,     0,     0, 0, 0);
      cyc("x99_T1", 0, 1, 9, 9, 0, 0, 0,     0,     0, 1, 0);
      cyc("x99_T2", 0, 0, 0, 9, 0, 1, 32'hAA, 32'hAA, 0, 1, 0);
      cyc("x99_T3", 0, 0, 0, 9, 0, 1, 32'hBB, 32'hBB, 0, 0, 0);
      cyc("x99_T4", 0, 0, 0, 9, 7, 0, 0,     32'hBB, 32'h11, 0, 0);

      // Unexpected write enable: sticky wb_err, write to x0 dropped
      cyc("err_T",  0, 0, 0, 0, 5, 1, 32'hDEADBEEF, 0, 32'h000ABCDE, 0, 0);
      cyc("err_T1", 0, 0, 0, 8, 5, 0, 0, 32'h22, 32'h000ABCDE, 0, 1);
      cyc("err_T2", 0, 0, 0, 9, 7, 0, 0, 32'hBB, 32'h11,       0, 1);
      cyc("err_rst",1, 0, 0, 5, 0, 0, 0, 32'h000ABCDE, 0,      0, 1);
      cyc("err_clr",0, 0, 0, 5, 8, 0, 0, 0,     0,             0, 0);

      // Reset mid-flight discards pending x3 write
      cyc("rmf_T",  0, 1, 3, 3, 0, 0, 0,            0, 0, 0, 0);
      cyc("rmf_T1", 1, 0, 0, 3, 0, 0, 0,            0, 0, 1, 0);
      cyc("rmf_T2", 0, 0, 0, 3, 0, 1, 32'h00001234, 0, 0, 0, 0);
      cyc("rmf_T3", 0, 0, 0, 3, 0, 0, 0,            0, 0, 0, 1);

      @(negedge clk);
      #1;
      checks++;
      if (exp_q.size() != 0) begin
         failures++;
         $display("FAIL drain: %0d entries left, expected 0", exp_q.size());
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
